ex_muldiv_unit: RTL and testbench
=================================

Name: ex_muldiv_unit

Overview:
- Iterative multiply/divide execution unit on the read side of the ID/EX pipeline register.
- Consumes the latched operands busA/busB, a 2-bit op code and the destination register Rd.
- Runs a shift-add multiply or a restoring divide over XLEN cycles.
- Holds busy_o high so the hazard logic freezes IF/ID and ID/EX until the result pulses out toward EX/MEM.

Parameters:
XLEN, 32, operand/result width; iteration count equals XLEN.
RD_W, 6, width of the destination register tag (matches ID/EX Rd).

Ports:
CLK  input  1  clock; all state updates on posedge.
Resetn  input  1  asynchronous active-low reset.
start_i  input  1  one-cycle request; operands valid this cycle.
op_i  input  2  00 MUL (low XLEN), 01 MULHU (high XLEN, unsigned), 10 DIVU, 11 REMU.
busA  input  XLEN  operand A (multiplicand / dividend) from ID/EX.
busB  input  XLEN  operand B (multiplier / divisor) from ID/EX.
Rd_i  input  RD_W  destination register tag from ID/EX.
flush_i  input  1  pipeline flush (branch/jump taken); aborts the operation.
busy_o  output  1  high while an operation is in flight; drives the pipeline stall.
done_o  output  1  one-cycle pulse: result_o/Rd_o/RegWr_o valid.
result_o  output  XLEN  operation result, held until the next done_o.
Rd_o  output  RD_W  captured Rd_i, held with result_o.
RegWr_o  output  1  equals done_o; write-back enable toward EX/MEM.

Behaviour:
- Reset (Resetn=0, asynchronous):
  - state=IDLE, counter=0.
  - busy_o=0, done_o=0, RegWr_o=0.
  - result_o=0, Rd_o=0; all internal accumulators cleared.
  - Reset mid-operation discards the operation; no done_o follows.
- States: IDLE, RUN, DONE.
- IDLE:
  - start_i=1 && flush_i=0: capture busA, busB, op_i, Rd_i; counter=0.
  - DIVU/REMU with busB==0 -> DONE next cycle.
  - Otherwise -> RUN.
  - busy_o is 1 from the cycle after start_i.
- RUN:
  - One iteration per cycle; counter increments.
  - After iteration XLEN-1 (counter==XLEN-1) -> DONE.
  - Multiply: 2*XLEN-bit product register, shift-add LSB-first.
  - Divide: restoring; XLEN-bit remainder, XLEN+1-bit trial subtract, quotient shifted in MSB-last.
- DONE:
  - done_o=1 and RegWr_o=1 for exactly one cycle; result_o and Rd_o updated the same cycle.
  - busy_o=0 in DONE.
  - -> IDLE next cycle.
- Latency: start_i at cycle t -> done_o at cycle t+XLEN+1 (33 for XLEN=32).
- Results:
  - MUL = product[XLEN-1:0].
  - MULHU = product[2XLEN-1:XLEN].
  - DIVU = quotient; REMU = remainder.
  - Divide by zero: DIVU = all ones, REMU = busA. done_o at t+2.
- Busy rules:
  - start_i while busy_o=1 or in DONE is ignored; the producer must hold the request under stall.
  - start_i in the DONE cycle is also ignored.
- Flush:
  - flush_i=1 in RUN -> IDLE next cycle; no done_o; result_o/Rd_o keep their previous values.
  - flush_i=1 with start_i=1 in IDLE: request dropped.
  - flush_i in DONE has no effect; the result pulse still issues.
- Wrap-around: counter is log2(XLEN) bits and never wraps in RUN; it is cleared on each accepted start.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined: MUL/MULHU with busA==0 or busB==0 skips RUN, goes IDLE->DONE with result 0 (done_o at t+2).
- Defined: MUL/MULHU also terminates early (-> DONE next cycle) when the remaining unshifted multiplier bits are all zero; result is identical to the full-length run.
- Not defined: every non-div-by-zero operation takes exactly XLEN RUN cycles; latency is fixed at t+XLEN+1.

Test Plan:
- Reset mid-run: start MUL 5*7, deassert Resetn at RUN cycle 10 -> all outputs 0 immediately; no done_o after Resetn rises.
- MUL: busA=0x0001_0003, busB=0x0000_0005, Rd_i=6'd9 -> done_o at t+33, result_o=0x0005_000F, Rd_o=9, RegWr_o=1 for one cycle; busy_o high t+1..t+32.
- MULHU: busA=busB=0xFFFF_FFFF -> result_o=0xFFFF_FFFE; same op as MUL -> result_o=0x0000_0001.
- DIVU/REMU: 100/7 -> DIVU 14, REMU 2. Divide by zero with busA=0x1234 -> DIVU 0xFFFF_FFFF, REMU 0x1234, done_o at t+2.
- Flush: start DIVU, assert flush_i at RUN cycle 5 -> busy_o=0 next cycle, no done_o, result_o unchanged. start_i pulsed during RUN -> ignored, first result unaffected.
- MULDIV_EARLY_OUT_EN:
  - Defined: MUL 3*0 -> done_o at t+2, result 0; MUL 3*4 -> done_o before t+33, result 12.
  - Not defined: MUL 3*4 -> done_o exactly at t+33, result 12.

Source files
------------

// File: rtl/ex_muldiv_unit_if.sv
// ex_muldiv_unit_if: request/result bundle between the ID/EX read side and
// the iterative multiply/divide unit.
// master = operand producer (pipeline), slave = ex_muldiv_unit.
interface ex_muldiv_unit_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RD_W = 6
);
  logic            start_i;
  logic [1:0]      op_i;
  logic [XLEN-1:0] busA;
  logic [XLEN-1:0] busB;
  logic [RD_W-1:0] Rd_i;
  logic            flush_i;
  logic            busy_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;
  logic [RD_W-1:0] Rd_o;
  logic            RegWr_o;

  modport master (
    output start_i, op_i, busA, busB, Rd_i, flush_i,
    input  busy_o, done_o, result_o, Rd_o, RegWr_o
  );

  modport slave (
    input  start_i, op_i, busA, busB, Rd_i, flush_i,
    output busy_o, done_o, result_o, Rd_o, RegWr_o
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative shift-add multiplier / restoring divider fed from
// the ID/EX register. One iteration per cycle, XLEN iterations per operation.
// busy_o stalls the front of the pipeline; done_o/RegWr_o pulse the result
// toward EX/MEM.
// Optional feature macro: MULDIV_EARLY_OUT_EN (multiply early termination).
module ex_muldiv_unit #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RD_W = 6
) (
  input  logic             CLK,
  input  logic             Resetn,
  ex_muldiv_unit_if.slave  mdu
);

  localparam int unsigned CW = (XLEN > 1) ? $clog2(XLEN) : 1;

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MULHU = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_REMU  = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state_q, state_d;

  logic [CW-1:0]     cnt_q;
  logic [1:0]        op_q;
  logic [RD_W-1:0]   rd_q;
  logic              short_q;

  logic [2*XLEN-1:0] prod_q;
  logic [2*XLEN-1:0] mcand_q;
  logic [XLEN-1:0]   mplier_q;

  logic [XLEN-1:0]   rem_q;
  logic [XLEN-1:0]   quot_q;
  logic [XLEN-1:0]   divisor_q;

  logic [XLEN-1:0]   result_q;
  logic [RD_W-1:0]   rd_out_q;

  logic              accept;
  logic              last_iter;
  logic              mul_early;
  logic              finish;
  logic              start_short;

  logic [2*XLEN-1:0] prod_nx;
  logic [2*XLEN-1:0] mcand_nx;
  logic [XLEN-1:0]   mplier_nx;
  logic [XLEN:0]     shifted;
  logic              ge;
  logic [XLEN-1:0]   rem_nx;
  logic [XLEN-1:0]   quot_nx;
  logic [XLEN-1:0]   res_d;

  assign accept    = (state_q == IDLE) && mdu.start_i && !mdu.flush_i;
  assign last_iter = (cnt_q == CW'(XLEN - 1));

  // One iteration of each algorithm, computed from the current working state
  always_comb begin
    prod_nx   = prod_q + (mplier_q[0] ? mcand_q : '0);
    mcand_nx  = mcand_q << 1;
    mplier_nx = mplier_q >> 1;
    shifted   = {rem_q, quot_q[XLEN-1]};
    ge        = (shifted >= {1'b0, divisor_q});
    // When ge holds the difference is below the divisor, so XLEN bits suffice
    rem_nx    = ge ? (shifted[XLEN-1:0] - divisor_q) : shifted[XLEN-1:0];
    quot_nx   = {quot_q[XLEN-2:0], ge};
  end

`ifdef MULDIV_EARLY_OUT_EN
  // Multiply may stop once no multiplier bits remain; remaining adds are zero
  always_comb begin
    mul_early   = !op_q[1] && (mplier_nx == '0);
    start_short = mdu.op_i[1] ? (mdu.busB == '0)
                              : ((mdu.busA == '0) || (mdu.busB == '0));
  end
`else
  // Fixed-latency build: only divide-by-zero takes the short path
  always_comb begin
    mul_early   = 1'b0;
    start_short = mdu.op_i[1] && (mdu.busB == '0);
  end
`endif

  assign finish = short_q || last_iter || mul_early;

  // Result selection for the cycle that enters DONE
  always_comb begin
    res_d = '0;
    if (short_q) begin
      // Short path: divide by zero, or a multiply with a zero operand
      unique case (op_q)
        OP_DIVU: res_d = '1;
        OP_REMU: res_d = quot_q;
        default: res_d = '0;
      endcase
    end else begin
      unique case (op_q)
        OP_MUL:   res_d = prod_nx[XLEN-1:0];
        OP_MULHU: res_d = prod_nx[2*XLEN-1:XLEN];
        OP_DIVU:  res_d = quot_nx;
        OP_REMU:  res_d = rem_nx;
        default:  res_d = '0;
      endcase
    end
  end

  // State register
  always_ff @(posedge CLK or negedge Resetn) begin
    if (!Resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic: flush aborts RUN only; DONE always issues its pulse
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = RUN;
      RUN: begin
        if (mdu.flush_i)  state_d = IDLE;
        else if (finish)  state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state and the held result registers
  always_comb begin
    mdu.busy_o   = (state_q == RUN);
    mdu.done_o   = (state_q == DONE);
    mdu.RegWr_o  = (state_q == DONE);
    mdu.result_o = result_q;
    mdu.Rd_o     = rd_out_q;
  end

  // Operand capture, iteration datapath and result latch
  always_ff @(posedge CLK or negedge Resetn) begin
    if (!Resetn) begin
      cnt_q     <= '0;
      op_q      <= '0;
      rd_q      <= '0;
      short_q   <= 1'b0;
      prod_q    <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      rem_q     <= '0;
      quot_q    <= '0;
      divisor_q <= '0;
      result_q  <= '0;
      rd_out_q  <= '0;
    end else if (accept) begin
      cnt_q     <= '0;
      op_q      <= mdu.op_i;
      rd_q      <= mdu.Rd_i;
      short_q   <= start_short;
      prod_q    <= '0;
      mcand_q   <= {{XLEN{1'b0}}, mdu.busA};
      mplier_q  <= mdu.busB;
      rem_q     <= '0;
      quot_q    <= mdu.busA;
      divisor_q <= mdu.busB;
    end else if (state_q == RUN) begin
      if (!last_iter) cnt_q <= cnt_q + CW'(1);
      if (op_q[1]) begin
        rem_q  <= rem_nx;
        quot_q <= quot_nx;
      end else begin
        prod_q   <= prod_nx;
        mcand_q  <= mcand_nx;
        mplier_q <= mplier_nx;
      end
      if (state_d == DONE) begin
        result_q <= res_d;
        rd_out_q <= rd_q;
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: directed and randomized checks of ex_muldiv_unit against
// a plain-arithmetic reference model. Honors MULDIV_EARLY_OUT_EN.
module tb_ex_muldiv_unit;

  localparam int unsigned XLEN = 32;
  localparam int unsigned RD_W = 6;

  logic CLK    = 1'b0;
  logic Resetn = 1'b0;

  int checks   = 0;
  int failures = 0;

  ex_muldiv_unit_if #(.XLEN(XLEN), .RD_W(RD_W)) mdu ();

  ex_muldiv_unit #(.XLEN(XLEN), .RD_W(RD_W)) dut (
    .CLK    (CLK),
    .Resetn (Resetn),
    .mdu    (mdu)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: results straight from unsigned arithmetic
  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint unsigned p;
    p = longint'(a) * longint'(b);
    case (op)
      2'b00:   return p[31:0];
      2'b01:   return p[63:32];
      2'b10:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Expected latency in cycles after start; 0 means "any value from 2 to 33"
  function automatic int ref_latency(input logic [1:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    if (op[1] && b == 0) return 2;
`ifdef MULDIV_EARLY_OUT_EN
    if (!op[1] && (a == 0 || b == 0)) return 2;
    if (!op[1]) return 0;
`endif
    return XLEN + 1;
  endfunction

  task automatic drive_idle();
    mdu.start_i = 1'b0;
    mdu.flush_i = 1'b0;
    mdu.op_i    = 2'b00;
    mdu.busA    = '0;
    mdu.busB    = '0;
    mdu.Rd_i    = '0;
  endtask

  // Present a one-cycle request; returns at the negedge where k=1 (cycle t+1)
  task automatic do_start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [5:0] rd);
    @(negedge CLK);
    mdu.start_i = 1'b1;
    mdu.op_i    = op;
    mdu.busA    = a;
    mdu.busB    = b;
    mdu.Rd_i    = rd;
    @(negedge CLK);
    drive_idle();
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [5:0] rd, input bit inject);
    int   k;
    bit   busy_ok;
    bit   seen;
    int   lat;
    logic [31:0] exp_res;
    exp_res = ref_result(op, a, b);
    lat     = ref_latency(op, a, b);
    do_start(op, a, b, rd);
    k       = 1;
    busy_ok = 1'b1;
    seen    = 1'b0;
    while (k <= 100) begin
      if (mdu.done_o) begin
        seen = 1'b1;
        break;
      end
      if (!mdu.busy_o) busy_ok = 1'b0;
      if (inject && k == 3) begin
        mdu.start_i = 1'b1;
        mdu.op_i    = ~op;
        mdu.busA    = ~a;
        mdu.busB    = b ^ 32'h5A5A_0001;
        mdu.Rd_i    = ~rd;
      end else if (inject && k == 4) begin
        drive_idle();
      end
      @(negedge CLK);
      k++;
    end
    check({name, "_done_seen"}, 64'(seen), 64'd1);
    if (lat != 0) check({name, "_latency"}, 64'(k), 64'(lat));
    else          check({name, "_latency_range"}, 64'(k >= 2 && k <= 33), 64'd1);
    check({name, "_result"}, 64'(mdu.result_o), 64'(exp_res));
    check({name, "_rd"}, 64'(mdu.Rd_o), 64'(rd));
    check({name, "_regwr"}, 64'(mdu.RegWr_o), 64'd1);
    check({name, "_busy_in_done"}, 64'(mdu.busy_o), 64'd0);
    check({name, "_busy_while_run"}, 64'(busy_ok), 64'd1);
    @(negedge CLK);
    check({name, "_done_one_cycle"}, 64'(mdu.done_o), 64'd0);
    check({name, "_result_held"}, 64'(mdu.result_o), 64'(exp_res));
  endtask

  // Watch a window of cycles for any unwanted completion or busy activity
  task automatic expect_quiet(input string name, input int cycles, input bit check_busy);
    bit bad_done;
    bit bad_busy;
    bad_done = 1'b0;
    bad_busy = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge CLK);
      if (mdu.done_o) bad_done = 1'b1;
      if (mdu.busy_o) bad_busy = 1'b1;
    end
    check({name, "_no_done"}, 64'(bad_done), 64'd0);
    if (check_busy) check({name, "_no_busy"}, 64'(bad_busy), 64'd0);
  endtask

  initial begin
    logic [31:0] held;
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    drive_idle();
    Resetn = 1'b0;
    repeat (2) @(negedge CLK);
    check("reset_busy", 64'(mdu.busy_o), 64'd0);
    check("reset_done", 64'(mdu.done_o), 64'd0);
    check("reset_regwr", 64'(mdu.RegWr_o), 64'd0);
    check("reset_result", 64'(mdu.result_o), 64'd0);
    check("reset_rd", 64'(mdu.Rd_o), 64'd0);
    Resetn = 1'b1;
    @(negedge CLK);

    // Directed arithmetic cases
    run_op("mul_basic", 2'b00, 32'h0001_0003, 32'h0000_0005, 6'd9, 1'b0);
    check("mul_basic_const", 64'(mdu.result_o), 64'h0005_000F);
    run_op("mulhu_ones", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd1, 1'b0);
    check("mulhu_ones_const", 64'(mdu.result_o), 64'hFFFF_FFFE);
    run_op("mul_ones", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd2, 1'b0);
    check("mul_ones_const", 64'(mdu.result_o), 64'h0000_0001);
    run_op("divu_100_7", 2'b10, 32'd100, 32'd7, 6'd3, 1'b0);
    check("divu_100_7_const", 64'(mdu.result_o), 64'd14);
    run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 6'd4, 1'b0);
    check("remu_100_7_const", 64'(mdu.result_o), 64'd2);
    run_op("divu_zero", 2'b10, 32'h1234, 32'd0, 6'd5, 1'b0);
    check("divu_zero_const", 64'(mdu.result_o), 64'hFFFF_FFFF);
    run_op("remu_zero", 2'b11, 32'h1234, 32'd0, 6'd6, 1'b0);
    check("remu_zero_const", 64'(mdu.result_o), 64'h1234);
    run_op("mul_3x0", 2'b00, 32'd3, 32'd0, 6'd7, 1'b0);
    run_op("mul_3x4", 2'b00, 32'd3, 32'd4, 6'd8, 1'b0);
    check("mul_3x4_const", 64'(mdu.result_o), 64'd12);

    // Start pulsed during RUN is ignored
    run_op("divu_inject", 2'b10, 32'hDEAD_BEEF, 32'd1000, 6'd10, 1'b1);
    run_op("after_inject", 2'b11, 32'd55, 32'd10, 6'd11, 1'b0);

    // Reset in the middle of a multiply
    do_start(2'b00, 32'd5, 32'd7, 6'd12);
    repeat (9) @(negedge CLK);
    Resetn = 1'b0;
    #1;
    check("rstmid_busy", 64'(mdu.busy_o), 64'd0);
    check("rstmid_done", 64'(mdu.done_o), 64'd0);
    check("rstmid_result", 64'(mdu.result_o), 64'd0);
    check("rstmid_rd", 64'(mdu.Rd_o), 64'd0);
    @(negedge CLK);
    Resetn = 1'b1;
    expect_quiet("rstmid", 40, 1'b1);

    // Flush during RUN of a divide
    run_op("pre_flush", 2'b00, 32'd21, 32'd2, 6'd13, 1'b0);
    held = mdu.result_o;
    do_start(2'b10, 32'd1000, 32'd3, 6'd14);
    repeat (4) @(negedge CLK);
    mdu.flush_i = 1'b1;
    @(negedge CLK);
    mdu.flush_i = 1'b0;
    check("flush_busy", 64'(mdu.busy_o), 64'd0);
    check("flush_result", 64'(mdu.result_o), 64'(held));
    check("flush_rd", 64'(mdu.Rd_o), 64'd13);
    expect_quiet("flush", 40, 1'b1);

    // Flush together with start in IDLE drops the request
    @(negedge CLK);
    mdu.start_i = 1'b1;
    mdu.flush_i = 1'b1;
    mdu.op_i    = 2'b10;
    mdu.busA    = 32'd9;
    mdu.busB    = 32'd0;
    @(negedge CLK);
    drive_idle();
    check("flushstart_busy", 64'(mdu.busy_o), 64'd0);
    expect_quiet("flushstart", 5, 1'b1);
    check("flushstart_result", 64'(mdu.result_o), 64'(held));

    // Randomized operations against the reference model
    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      if (i % 6 == 0)      rb = 32'd0;
      else if (i % 4 == 1) rb = 32'($urandom_range(1, 255));
      else                 rb = $urandom;
      if (i % 7 == 3) ra = 32'd0;
      run_op($sformatf("rand%0d", i), rop, ra, rb, 6'($urandom_range(0, 63)),
             (rop[1] && rb != 0 && (i % 5 == 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the bench always terminates
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
